// File: rtl/ask_envelope_demod.sv
// ASK envelope demodulator: rectify-and-integrate over SPB samples per bit,
// slice against a threshold, and assemble NBITS bits into a codeword.
module ask_envelope_demod #(
  parameter  int SAMPLE_W = 16,
  parameter  int SPB      = 32,
  parameter  int NBITS    = 8,
  localparam int ACC_W    = SAMPLE_W + $clog2(SPB)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic [ACC_W-1:0]           thresh,
  output logic [NBITS-1:0]           codeword,
  output logic                       codeword_valid,
  output logic                       busy
);

  localparam int SC_W = $clog2(SPB);
  localparam int BC_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [SC_W-1:0]     LAST_SAMPLE = SC_W'(SPB - 1);
  localparam logic [BC_W-1:0]     LAST_BIT    = BC_W'(NBITS - 1);
  localparam logic [SAMPLE_W-2:0] MAG_MAX     = '1;

  typedef enum logic {IDLE, ACQ} state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [SC_W-1:0]     sample_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic [NBITS-1:0]    shift;
  logic [SAMPLE_W-2:0] mag;
  logic                bit_now;
  logic                win_close;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mag = sample[SAMPLE_W-2:0];
    if (sample[SAMPLE_W-1]) begin
      // The most negative sample has no positive twin; clamp it to full scale.
      if (sample[SAMPLE_W-2:0] == '0) mag = MAG_MAX;
      else                            mag = ~sample[SAMPLE_W-2:0] + (SAMPLE_W-1)'(1);
    end
    acc_next  = acc + ACC_W'(mag);
    bit_now   = (acc_next > thresh);
    win_close = (sample_cnt == LAST_SAMPLE);
  end

  assign busy = (state == ACQ);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      sample_cnt     <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      codeword       <= '0;
      codeword_valid <= 1'b0;
    end else begin
      codeword_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACQ;
            acc        <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
          end
        end
        ACQ: begin
          if (sample_valid) begin
            if (win_close) begin
              acc        <= '0;
              sample_cnt <= '0;
              bit_cnt    <= bit_cnt + BC_W'(1);
              shift      <= {shift[NBITS-2:0], bit_now};
              if (bit_cnt == LAST_BIT) begin
                codeword       <= {shift[NBITS-2:0], bit_now};
                codeword_valid <= 1'b1;
                state          <= IDLE;
              end
            end else begin
              acc        <= acc_next;
              sample_cnt <= sample_cnt + SC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ask_envelope_demod.sv
// Self-checking bench for ask_envelope_demod: scenario tasks driving frames and
// comparing against a window-sum reference model of the demodulator.
module tb_ask_envelope_demod;

  localparam int SPB   = 32;
  localparam int NBITS = 8;
  localparam int FRAME = SPB * NBITS;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic [20:0]        thresh = '0;
  logic [7:0]         codeword;
  logic               codeword_valid;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int stim [FRAME];

  always #5 clk = ~clk;

  ask_envelope_demod #(.SAMPLE_W(16), .SPB(SPB), .NBITS(NBITS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sample_valid   (sample_valid),
    .sample         (sample),
    .thresh         (thresh),
    .codeword       (codeword),
    .codeword_valid (codeword_valid),
    .busy           (busy)
  );

  // Reference: sum |sample| per window, slice strictly, first bit ends in the MSB.
  function automatic logic [7:0] model_cw(input logic [20:0] thr);
    logic [7:0] cw = '0;
    for (int b = 0; b < NBITS; b++) begin
      longint sum = 0;
      for (int k = 0; k < SPB; k++) begin
        int a = stim[b*SPB + k];
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        sum += a;
      end
      cw = {cw[6:0], (sum > longint'(thr))};
    end
    return cw;
  endfunction

  task automatic load_pattern(input logic [7:0] pat, input bit alternate);
    for (int b = 0; b < NBITS; b++)
      for (int k = 0; k < SPB; k++)
        stim[b*SPB + k] = pat[7-b] ? ((alternate && (k % 2 == 1)) ? -1000 : 1000) : 0;
  endtask

  // Drives one frame from stim; outputs are observed on negedges only.
  task automatic drive_frame(input bit skip_start, input int gap_pct, input int start_a,
                             input int start_b, input bit b2b_next, output int pulses,
                             output int busy_cyc, output bit lat_ok, output logic [7:0] cw_seen,
                             output bit timeout);
    int i = 0;
    int cyc = 0;
    pulses = 0; busy_cyc = 0; lat_ok = 0; cw_seen = '0; timeout = 0;
    if (!skip_start) begin
      @(negedge clk); start = 1'b1; sample_valid = 1'b0;
      @(negedge clk); start = 1'b0;
    end
    while (i < FRAME) begin
      if (busy) busy_cyc++;
      if (codeword_valid) pulses++;
      if (cyc++ > 5000) begin timeout = 1; break; end
      if (int'($urandom_range(99)) < gap_pct) begin
        sample_valid = 1'b0; sample = 16'($urandom); start = 1'b0;
      end else begin
        sample_valid = 1'b1; sample = 16'(stim[i]);
        start = (i == start_a) || (i == start_b);
        i++;
      end
      @(negedge clk);
    end
    start = 1'b0; sample_valid = 1'b0;
    lat_ok  = codeword_valid && !busy;
    cw_seen = codeword;
    if (codeword_valid) pulses++;
    if (b2b_next) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
    end else begin
      repeat (3) begin @(negedge clk); if (codeword_valid) pulses++; end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (codeword !== 8'h00) begin errors++; $display("FAIL reset_codeword: got %h want 00", codeword); end
    checks++; if (codeword_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", codeword_valid); end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sample_valid = 1'b1; sample = 16'($urandom);
      @(negedge clk);
      if (busy !== 1'b0 || codeword_valid !== 1'b0) bad++;
    end
    sample_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_ignores_samples: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_basic();
    int p, bc; bit lat, to; logic [7:0] cw;
    load_pattern(8'hB2, 0); thresh = 21'd16000;
    drive_frame(0, 0, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got timeout want completion"); end
    checks++; if (cw !== 8'hB2) begin errors++; $display("FAIL basic_cw: got %h want b2", cw); end
    checks++; if (cw !== model_cw(thresh)) begin errors++; $display("FAIL basic_model: got %h want %h", cw, model_cw(thresh)); end
    checks++; if (!lat) begin errors++; $display("FAIL basic_latency: got no pulse want pulse 1 cycle after sample 256"); end
    checks++; if (p != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", p); end
    checks++; if (bc != FRAME) begin errors++; $display("FAIL basic_busy: got %0d want %0d", bc, FRAME); end
  endtask

  task automatic test_rectify();
    int p, bc; bit lat, to; logic [7:0] cw;
    load_pattern(8'hB2, 1); thresh = 21'd16000;
    drive_frame(0, 0, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (cw !== 8'hB2) begin errors++; $display("FAIL rect_alt_cw: got %h want b2", cw); end
    for (int i = 0; i < FRAME; i++) stim[i] = (i < SPB) ? -32768 : 0;
    thresh = 21'd1048543;
    drive_frame(0, 0, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (cw !== 8'h80) begin errors++; $display("FAIL rect_sat_above: got %h want 80", cw); end
    thresh = 21'd1048544;
    drive_frame(0, 0, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (cw !== 8'h00) begin errors++; $display("FAIL rect_sat_equal: got %h want 00", cw); end
  endtask

  task automatic test_threshold();
    int p, bc; bit lat, to; logic [7:0] cw;
    load_pattern(8'hB2, 0);
    for (int k = 0; k < SPB; k++) stim[k] = (k < 16) ? ($urandom_range(1) ? 1000 : -1000) : 0;
    thresh = 21'd16000;
    drive_frame(0, 0, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (cw !== 8'h32) begin errors++; $display("FAIL thresh_equal: got %h want 32", cw); end
    thresh = 21'd15999;
    drive_frame(0, 0, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (cw !== 8'hB2) begin errors++; $display("FAIL thresh_below: got %h want b2", cw); end
  endtask

  task automatic test_gapped();
    int p, bc; bit lat, to; logic [7:0] cw;
    load_pattern(8'hB2, 0); thresh = 21'd16000;
    drive_frame(0, 40, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (to) begin errors++; $display("FAIL gap_timeout: got timeout want completion"); end
    checks++; if (cw !== 8'hB2) begin errors++; $display("FAIL gap_cw: got %h want b2", cw); end
    checks++; if (!lat) begin errors++; $display("FAIL gap_latency: got no pulse want pulse after last sample"); end
    checks++; if (p != 1) begin errors++; $display("FAIL gap_pulses: got %0d want 1", p); end
  endtask

  task automatic test_random();
    int p, bc; bit lat, to; logic [7:0] cw; logic signed [15:0] r;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        r = 16'($urandom);
        stim[i] = ($urandom_range(9) == 0) ? -32768 : int'(r);
      end
      thresh = 21'($urandom_range(650000, 400000));
      drive_frame(0, 20, -1, -1, 0, p, bc, lat, cw, to);
      checks++; if (cw !== model_cw(thresh) || p != 1) begin
        errors++; $display("FAIL random_frame%0d: got %h pulses=%0d want %h pulses=1", f, cw, p, model_cw(thresh));
      end
    end
  endtask

  task automatic test_start_ignored();
    int p, bc; bit lat, to; logic [7:0] cw;
    load_pattern(8'hB2, 0); thresh = 21'd16000;
    drive_frame(0, 0, 50, 255, 0, p, bc, lat, cw, to);
    checks++; if (cw !== 8'hB2) begin errors++; $display("FAIL start_ign_cw: got %h want b2", cw); end
    checks++; if (p != 1 || !lat) begin errors++; $display("FAIL start_ign_pulse: got %0d lat=%b want 1 lat=1", p, lat); end
    checks++; if (bc != FRAME) begin errors++; $display("FAIL start_ign_busy: got %0d want %0d", bc, FRAME); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_ign_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int p, bc, bad; bit lat, to; logic [7:0] cw;
    load_pattern(8'hB2, 0); thresh = 21'd16000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample_valid = 1'b1; sample = 16'(stim[i]); @(negedge clk);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (codeword !== 8'h00) begin errors++; $display("FAIL midrst_codeword: got %h want 00", codeword); end
    bad = 0;
    for (int i = 100; i < 400; i++) begin
      sample = 16'(stim[i % FRAME]);
      @(negedge clk);
      if (codeword_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    sample_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d active cycles want 0", bad); end
    drive_frame(0, 0, -1, -1, 0, p, bc, lat, cw, to);
    checks++; if (cw !== 8'hB2 || p != 1) begin errors++; $display("FAIL midrst_fresh: got %h pulses=%0d want b2 pulses=1", cw, p); end
  endtask

  task automatic test_back_to_back();
    int p1, p2, bc; bit lat1, lat2, to; logic [7:0] cw1, cw2;
    load_pattern(8'hB2, 0); thresh = 21'd16000;
    drive_frame(0, 0, -1, -1, 1, p1, bc, lat1, cw1, to);
    load_pattern(8'h4D, 0);
    drive_frame(1, 0, -1, -1, 0, p2, bc, lat2, cw2, to);
    checks++; if (cw1 !== 8'hB2 || !lat1) begin errors++; $display("FAIL b2b_first: got %h lat=%b want b2 lat=1", cw1, lat1); end
    checks++; if (cw2 !== 8'h4D || cw2 !== model_cw(thresh)) begin errors++; $display("FAIL b2b_second: got %h want 4d", cw2); end
    checks++; if (!lat2 || p2 != 1) begin errors++; $display("FAIL b2b_spacing: got lat=%b pulses=%0d want lat=1 pulses=1", lat2, p2); end
    checks++; if (bc != FRAME) begin errors++; $display("FAIL b2b_busy: got %0d want %0d", bc, FRAME); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_rectify();
    test_threshold();
    test_gapped();
    test_random();
    test_start_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ask_envelope_demod.md
Name: ask_envelope_demod

Overview:
- Receive-side ASK demodulator between the noisy channel (after the CORDIC carrier modulator and noise injection) and the Hamming SEC-DED decoder.
- Takes a stream of signed carrier samples, rectifies each one, and integrates over a fixed samples-per-bit window.
- Slices each window against a programmable threshold to recover one bit.
- Assembles NBITS recovered bits into a codeword and presents it with a one-cycle valid pulse to the decoder stage.

Parameters:
- SAMPLE_W, 16, signed sample width.
- SPB, 32, samples per bit window; >=2.
- NBITS, 8, bits per codeword (Hamming 8,4 SEC-DED).
- ACC_W (localparam), SAMPLE_W+$clog2(SPB), accumulator/threshold width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a codeword frame; sampled only in IDLE.
- sample_valid  in  1  sample qualifier; may gap arbitrarily.
- sample  in  SAMPLE_W  signed two's-complement carrier sample.
- thresh  in  ACC_W  unsigned slicing threshold; sampled at each window close.
- codeword  out  NBITS  last recovered codeword.
- codeword_valid  out  1  one-cycle pulse when codeword updates.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, acc=0, sample_cnt=0, bit_cnt=0, shift=0, codeword=0, codeword_valid=0, busy=0. Applies mid-frame; the partial frame is discarded and no valid pulse is produced.
- FSM has two states.
  - IDLE: start=1 moves to ACQ and clears acc, sample_cnt, bit_cnt and shift. sample_valid is ignored in IDLE.
  - ACQ: start is ignored. busy=1 exactly while state==ACQ.
- Rectify: |sample| is unsigned SAMPLE_W-1 bits. The most negative value (-2^(SAMPLE_W-1)) saturates to 2^(SAMPLE_W-1)-1.
- Per accepted sample (ACQ and sample_valid): acc_next = acc + |sample|. ACC_W is sized so the sum cannot wrap. Cycles without sample_valid hold all state.
- Window close: the accepted sample with sample_cnt==SPB-1.
  - bit = (acc_next > thresh). The comparison is strict; equality gives 0.
  - The bit shifts into shift at the LSB, so the first received bit ends in codeword[NBITS-1].
  - acc and sample_cnt clear and bit_cnt increments.
- Frame close: the window close with bit_cnt==NBITS-1.
  - On that same edge, codeword <= {shift[NBITS-2:0], bit} and codeword_valid <= 1.
  - State returns to IDLE, so busy falls.
  - codeword_valid is high for exactly the following cycle, then 0.
- Latency: codeword_valid is visible in the cycle after the edge that accepts sample NBITS*SPB.
- codeword holds its value between frames. It is not cleared by start.
- A start asserted in the cycle codeword_valid is high is accepted (the state is IDLE), so back-to-back frames are supported.
- A start coincident with the final sample is ignored, because the state is still ACQ at that edge.

Test Plan:
1. Basic frame. SPB=32, thresh=16000, start, then bits 1,0,1,1,0,0,1,0: 32 samples of +1000 for a '1', 32 samples of 0 for a '0', sample_valid continuous.
   - Required: codeword=8'hB2, a single codeword_valid pulse 1 cycle after the 256th sample, busy high for 256 cycles.
2. Rectification. '1' windows alternate +1000/-1000 → same codeword as test 1. A window of 32 × -32768 with thresh=1048543 → bit=1 (acc=1048544, no wrap).
3. Threshold boundary. One window summing exactly 16000 with thresh=16000 → that bit=0. Setting thresh=15999 → bit=1.
4. Gapped input. The test-1 stimulus with sample_valid randomly low on about 40% of cycles → codeword=8'hB2, exactly one valid pulse, no extra bits.
5. Control corners.
   - start pulsed at samples 50 and 255 → ignored; result identical to test 1.
   - rst at sample 100 → busy=0, codeword=0, no valid pulse.
   - A fresh frame after reset decodes 8'hB2.
6. Back-to-back. start asserted in the codeword_valid cycle, second frame 8'h4D → two pulses separated by 256 accepted samples, codeword 8'hB2 then 8'h4D.
